psu_meascollect: RTL and testbench
==================================

// Module: psu_meascollect
// PURPOSE
// - Gather direction of PSU mask extension: collects per-physical-qubit measurement results (NUM_PQ bits)
//   back into per-PCU result arrays (NUM_MASK bits), indexed by each PCU's patch.
// - Drives the uc_counter/qb_counter scan seen by the UC/QB controllers. Samples one (ucsel,qbsel) step per accepted beat.
// - Sits between the qubit-side measurement path and the PCU result writeback.
// PARAMETERS
// - NUM_PCU     2   PCUs; per-PCU slice width NUM_PCUQB = NUM_UC*NUM_QB
// - NUM_PCH     4   patches; PCHADDR_BW = log2(NUM_PCH)
// - NUM_UC      4   unit cells per patch; UCADDR_BW = log2(NUM_UC)
// - NUM_QB      4   qubits per unit cell; QBADDR_BW = log2(NUM_QB)
// - NUM_UCC     2   UC controllers; UC_STEPS = NUM_UC/NUM_UCC
// - NUM_QBCTRL  2   QB controllers; QB_STEPS = NUM_QB/NUM_QBCTRL; NUM_STEP = UC_STEPS*QB_STEPS
// PORTS
// - clk              in   1                     clock
// - rst              in   1                     synchronous, active-high reset
// - start            in   1                     begin collection; accepted only when start_ready=1
// - start_ready      out  1                     1 in IDLE
// - pchidx_list      in   NUM_PCU*PCHADDR_BW    patch per PCU, latched on start
// - pivalid_list     in   NUM_PCU               PCU valid, latched on start
// - mask_array       in   NUM_MASK              per-PCU qubit mask, latched on start
// - uc_counter       out  NUM_UCC*UCADDR_BW     UCC j field = ucsel*NUM_UCC + j
// - qb_counter       out  NUM_QBCTRL*QBADDR_BW  QBCTRL k field = qbsel*NUM_QBCTRL + k
// - meas_in_valid    in   1                     meas_ext_array valid for current step
// - meas_ext_array   in   NUM_PQ                bit pch*NUM_UC*NUM_QB + uc*NUM_QB + qb
// - meas_array       out  NUM_MASK              bit i*NUM_PCUQB + uc*NUM_QB + qb
// - out_valid        out  1                     meas_array complete
// - out_ready        in   1                     consumer accepts meas_array
// - meas_parity      out  NUM_PCU               see CONFIGURATION
// BEHAVIOUR
// - Reset: state IDLE, step=0, meas_array=0, out_valid=0, start_ready=1, meas_parity=0, latched lists/mask=0.
// - FSM IDLE -> COLLECT on start (same edge: latch lists/mask, clear meas_array, step=0).
// - COLLECT: ucsel=step/QB_STEPS, qbsel=step%QB_STEPS, registered, so counters are stable for the whole step.
//   On meas_in_valid: for each PCU i with valid, UCC j, QBCTRL k: uc=ucsel*NUM_UCC+j, qb=qbsel*NUM_QBCTRL+k,
//   meas_array[i*NUM_PCUQB+uc*NUM_QB+qb] <= meas_ext_array[pch_i*NUM_PCUQB+uc*NUM_QB+qb] & mask bit. step++.
//   No meas_in_valid: hold the step. After the beat at step=NUM_STEP-1: go to DONE and set step=0.
// - DONE: out_valid=1, meas_array held stable; out_ready -> IDLE, out_valid=0 on the next cycle.
// - Latency: exactly NUM_STEP accepted beats; out_valid rises the cycle after the last beat.
// - start in COLLECT/DONE ignored; meas_in_valid in IDLE/DONE ignored.
// - Invalid PCU: slice stays 0. Two valid PCUs on the same pch: both receive identical data (legal).
// - Mask bit 0 forces the result bit to 0. Counters read 0 in IDLE/DONE.
// - rst mid-COLLECT/DONE: immediate return to reset values; the partial result is discarded.
// - start and out_ready in the same DONE cycle: only out_ready is acted on; start is accepted next cycle in IDLE.
// CONFIGURATION
// - PSU_MEASCOL_PARITY_EN defined: meas_parity[i] = XOR of the final meas_array slice i.
//   Updated on the DONE entry edge, valid with out_valid, cleared on start.
// - Undefined: meas_parity tied to 0; no parity logic.
// TESTING
// - Reset: rst 2 cycles -> start_ready=1, out_valid=0, meas_array=0, counters 0.
// - PCU0 valid pch=2, mask=all1, meas_ext_array[47:32]=16'hA5C3 held, 4 beats -> meas_array[15:0]=16'hA5C3,
//   [31:16]=0; with parity: meas_parity=2'b00 (8 ones).
// - PCU0 pch=1 mask 16'h00FF, PCU1 pch=1 mask 16'hFF00, region=16'hFFFF -> meas_array=32'hFF0000FF.
// - Gapped meas_in_valid (1,0,0,1,1,0,1) -> counters step (0,0),(0,1),(1,0),(1,1) as uc/qb sel;
//   out_valid rises after the 4th valid beat only.
// - out_ready=0 for 5 cycles in DONE -> out_valid and meas_array stable; start ignored; out_ready=1 -> IDLE.
// - rst after 2 beats -> IDLE; a new start with pivalid=0 -> meas_array=0 after 4 beats.

Source files
------------

// File: rtl/psu_meascollect.sv
// Gathers per-physical-qubit measurement bits back into per-PCU result arrays by patch.
// Optional build macro PSU_MEASCOL_PARITY_EN adds a per-PCU XOR of the final result slice.
module psu_meascollect #(
    parameter int NUM_PCU    = 2,
    parameter int NUM_PCH    = 4,
    parameter int NUM_UC     = 4,
    parameter int NUM_QB     = 4,
    parameter int NUM_UCC    = 2,
    parameter int NUM_QBCTRL = 2,
    localparam int PCHADDR_BW = $clog2(NUM_PCH),
    localparam int UCADDR_BW  = $clog2(NUM_UC),
    localparam int QBADDR_BW  = $clog2(NUM_QB),
    localparam int NUM_PCUQB  = NUM_UC * NUM_QB,
    localparam int NUM_MASK   = NUM_PCU * NUM_PCUQB,
    localparam int NUM_PQ     = NUM_PCH * NUM_PCUQB
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic                             start_ready,
    input  logic [NUM_PCU*PCHADDR_BW-1:0]    pchidx_list,
    input  logic [NUM_PCU-1:0]               pivalid_list,
    input  logic [NUM_MASK-1:0]              mask_array,
    output logic [NUM_UCC*UCADDR_BW-1:0]     uc_counter,
    output logic [NUM_QBCTRL*QBADDR_BW-1:0]  qb_counter,
    input  logic                             meas_in_valid,
    input  logic [NUM_PQ-1:0]                meas_ext_array,
    output logic [NUM_MASK-1:0]              meas_array,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_PCU-1:0]               meas_parity
);

    localparam int UC_STEPS = NUM_UC / NUM_UCC;
    localparam int QB_STEPS = NUM_QB / NUM_QBCTRL;
    localparam int NUM_STEP = UC_STEPS * QB_STEPS;
    localparam int STEP_BW  = (NUM_STEP > 1) ? $clog2(NUM_STEP) : 1;
    localparam int UCSEL_BW = (UC_STEPS > 1) ? $clog2(UC_STEPS) : 1;
    localparam int QBSEL_BW = (QB_STEPS > 1) ? $clog2(QB_STEPS) : 1;
    localparam int MIDX_BW  = (NUM_MASK > 1) ? $clog2(NUM_MASK) : 1;
    localparam int PIDX_BW  = (NUM_PQ > 1) ? $clog2(NUM_PQ) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t                               state_q, state_d;
    logic [STEP_BW-1:0]                   step_q, step_d;
    logic [UCSEL_BW-1:0]                  ucsel_q;
    logic [QBSEL_BW-1:0]                  qbsel_q;
    logic [NUM_PCU-1:0][PCHADDR_BW-1:0]   pch_q;
    logic [NUM_PCU-1:0]                   pivalid_q;
    logic [NUM_MASK-1:0]                  mask_q;
    logic [NUM_MASK-1:0]                  meas_q, meas_d;
    logic [MIDX_BW-1:0]                   widx;
    logic [PIDX_BW-1:0]                   ridx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            step_q    <= '0;
            ucsel_q   <= '0;
            qbsel_q   <= '0;
            pch_q     <= '0;
            pivalid_q <= '0;
            mask_q    <= '0;
            meas_q    <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            meas_q  <= meas_d;
            // Selects are registered from the next step so the counters hold for the whole step.
            ucsel_q <= UCSEL_BW'(int'(step_d) / QB_STEPS);
            qbsel_q <= QBSEL_BW'(int'(step_d) % QB_STEPS);
            if (state_q == IDLE && start) begin
                pch_q     <= pchidx_list;
                pivalid_q <= pivalid_list;
                mask_q    <= mask_array;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        meas_d  = meas_q;
        widx    = '0;
        ridx    = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COLLECT;
                    step_d  = '0;
                    meas_d  = '0;
                end
            end
            COLLECT: begin
                if (meas_in_valid) begin
                    for (int i = 0; i < NUM_PCU; i++) begin
                        for (int j = 0; j < NUM_UCC; j++) begin
                            for (int k = 0; k < NUM_QBCTRL; k++) begin
                                widx = MIDX_BW'(i * NUM_PCUQB
                                       + (int'(ucsel_q) * NUM_UCC + j) * NUM_QB
                                       + int'(qbsel_q) * NUM_QBCTRL + k);
                                ridx = PIDX_BW'(int'(pch_q[i]) * NUM_PCUQB
                                       + (int'(ucsel_q) * NUM_UCC + j) * NUM_QB
                                       + int'(qbsel_q) * NUM_QBCTRL + k);
                                meas_d[widx] = pivalid_q[i] & mask_q[widx] & meas_ext_array[ridx];
                            end
                        end
                    end
                    if (step_q == STEP_BW'(NUM_STEP - 1)) begin
                        state_d = DONE;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + STEP_BW'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        uc_counter = '0;
        qb_counter = '0;
        if (state_q == COLLECT) begin
            for (int j = 0; j < NUM_UCC; j++)
                uc_counter[j*UCADDR_BW +: UCADDR_BW] = UCADDR_BW'(int'(ucsel_q) * NUM_UCC + j);
            for (int k = 0; k < NUM_QBCTRL; k++)
                qb_counter[k*QBADDR_BW +: QBADDR_BW] = QBADDR_BW'(int'(qbsel_q) * NUM_QBCTRL + k);
        end
    end

    assign start_ready = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign meas_array  = meas_q;

`ifdef PSU_MEASCOL_PARITY_EN
    logic [NUM_PCU-1:0] parity_q;

    // Parity is taken from the next-state array so the final beat is included.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= '0;
        end else if (state_q == IDLE && start) begin
            parity_q <= '0;
        end else if (state_q == COLLECT && state_d == DONE) begin
            for (int i = 0; i < NUM_PCU; i++)
                parity_q[i] <= ^meas_d[i*NUM_PCUQB +: NUM_PCUQB];
        end
    end

    assign meas_parity = parity_q;
`else
    assign meas_parity = '0;
`endif

endmodule

// File: tb/tb_psu_meascollect.sv
// Scoreboard bench for psu_meascollect: random and directed collections checked against a bit-level model.
module tb_psu_meascollect;

    localparam int W = 34;

    logic        clk;
    logic        rst;
    logic        start;
    logic        start_ready;
    logic [3:0]  pchidx_list;
    logic [1:0]  pivalid_list;
    logic [31:0] mask_array;
    logic [3:0]  uc_counter;
    logic [3:0]  qb_counter;
    logic        meas_in_valid;
    logic [63:0] meas_ext_array;
    logic [31:0] meas_array;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  meas_parity;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    psu_meascollect dut (
        .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
        .pchidx_list(pchidx_list), .pivalid_list(pivalid_list), .mask_array(mask_array),
        .uc_counter(uc_counter), .qb_counter(qb_counter),
        .meas_in_valid(meas_in_valid), .meas_ext_array(meas_ext_array),
        .meas_array(meas_array), .out_valid(out_valid), .out_ready(out_ready),
        .meas_parity(meas_parity)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Each result bit (i,uc,qb) is written in the step owning that uc/qb pair.
    function automatic logic [W-1:0] model(input logic [3:0] pchs, input logic [1:0] pv,
                                           input logic [31:0] mask, input logic [63:0] ext [4]);
        logic [31:0] res;
        logic [1:0]  par;
        res = '0;
        par = '0;
        for (int i = 0; i < 2; i++) begin
            int p;
            p = int'(pchs[i*2 +: 2]);
            for (int uc = 0; uc < 4; uc++) begin
                for (int qb = 0; qb < 4; qb++) begin
                    int s;
                    s = (uc / 2) * 2 + (qb / 2);
                    res[i*16 + uc*4 + qb] = pv[i] & mask[i*16 + uc*4 + qb] & ext[s][p*16 + uc*4 + qb];
                end
            end
`ifdef PSU_MEASCOL_PARITY_EN
            par[i] = ^res[i*16 +: 16];
`endif
        end
        return {par, res};
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_start_ready"}, 64'(start_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_meas_array"}, 64'(meas_array), 64'd0);
        check({tag, "_counters"}, 64'({uc_counter, qb_counter}), 64'd0);
        check({tag, "_parity"}, 64'(meas_parity), 64'd0);
    endtask

    // gap_mode: 0 always valid, 1 fixed pattern 1,0,0,1,1,0,1, 2 random
    task automatic do_txn(input logic [3:0] pchs, input logic [1:0] pv, input logic [31:0] mask,
                          input int gap_mode, input bit fix_en, input int fix_pch,
                          input logic [15:0] fix_val, input int abort_at);
        logic [63:0] ext [4];
        bit          gap_pat [7];
        int          beats;
        int          cyc;
        bit          v;
        int          us;
        int          qs;
        gap_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int b = 0; b < 4; b++) begin
            ext[b] = {$urandom, $urandom};
            if (fix_en) ext[b][fix_pch*16 +: 16] = fix_val;
        end
        cyc = 0;
        while (!start_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        start = 1'b1;
        pchidx_list = pchs;
        pivalid_list = pv;
        mask_array = mask;
        @(negedge clk);
        start = 1'b0;
        pchidx_list = 4'($urandom);
        pivalid_list = 2'($urandom);
        mask_array = $urandom;
        if (abort_at == 0) exp_q.push_back(model(pchs, pv, mask, ext));
        beats = 0;
        cyc = 0;
        while (beats < 4 && cyc < 100) begin
            if (abort_at != 0 && beats == abort_at) break;
            us = beats / 2;
            qs = beats % 2;
            check("collect_out_valid", 64'(out_valid), 64'd0);
            check("uc_counter", 64'(uc_counter), 64'({2'(us*2 + 1), 2'(us*2)}));
            check("qb_counter", 64'(qb_counter), 64'({2'(qs*2 + 1), 2'(qs*2)}));
            case (gap_mode)
                1:       v = (cyc < 7) ? gap_pat[cyc] : 1'b1;
                2:       v = ($urandom_range(0, 2) != 0);
                default: v = 1'b1;
            endcase
            meas_in_valid = v;
            meas_ext_array = v ? ext[beats] : {$urandom, $urandom};
            start = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (v) beats++;
            cyc++;
        end
        meas_in_valid = 1'b0;
        start = 1'b0;
        if (abort_at != 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_reset_values("abort");
        end else begin
            check("beat_count", 64'(beats), 64'd4);
            check("done_latency", 64'(out_valid), 64'd1);
        end
    endtask

    task automatic drain(input int hold, input bit poke_start);
        logic [31:0] snap;
        int          t;
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("done_wait", 64'(out_valid), 64'd1);
        snap = meas_array;
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            start = poke_start;
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'(meas_array), 64'(snap));
        end
        out_ready = 1'b1;
        start = poke_start;
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b0;
        check("ret_idle", 64'(start_ready), 64'd1);
        check("valid_drop", 64'(out_valid), 64'd0);
    endtask

    // monitor: pops the expected queue whenever a result is presented
    initial begin
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (out_valid && !prev_valid) begin
                    if (exp_q.size() == 0) check("unexpected_result", 64'd1, 64'd0);
                    else check("result", 64'({meas_parity, meas_array}), 64'(exp_q.pop_front()));
                end
                prev_valid = out_valid;
            end
        end
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        pchidx_list = '0;
        pivalid_list = '0;
        mask_array = '0;
        meas_in_valid = 1'b0;
        meas_ext_array = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_values("reset");

        // PCU0 on patch 2, region holds A5C3
        do_txn(4'b0010, 2'b01, 32'hFFFF_FFFF, 0, 1'b1, 2, 16'hA5C3, 0);
        drain(0, 1'b0);

        // two PCUs sharing patch 1 with complementary masks
        do_txn(4'b0101, 2'b11, 32'hFF00_00FF, 0, 1'b1, 1, 16'hFFFF, 0);
        drain(1, 1'b0);

        // gapped valid pattern
        do_txn(4'($urandom), 2'b11, 32'hFFFF_FFFF, 1, 1'b0, 0, 16'h0, 0);
        drain(0, 1'b0);

        // long back-pressure with start poked during DONE
        do_txn(4'($urandom), 2'b11, $urandom, 2, 1'b0, 0, 16'h0, 0);
        drain(5, 1'b1);

        // reset mid-collection, then a collection with no valid PCU
        do_txn(4'($urandom), 2'b11, 32'hFFFF_FFFF, 0, 1'b0, 0, 16'h0, 2);
        do_txn(4'($urandom), 2'b00, 32'hFFFF_FFFF, 0, 1'b0, 0, 16'h0, 0);
        drain(0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            do_txn(4'($urandom), 2'($urandom), $urandom, 2, 1'b0, 0, 16'h0, 0);
            drain($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
